// File: rtl/counter_seq_pkg.sv
// rtl/counter_seq_pkg.sv - Shared encodings and constants for the counter sequencer
package counter_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LIMIT = 2'b11
  } state_t;

  // Event codes double as priority rank: the larger code wins a same-cycle collision.
  typedef enum logic [2:0] {
    EV_NONE  = 3'd0,
    EV_SEL   = 3'd1,
    EV_DIR   = 3'd2,
    EV_START = 3'd3,
    EV_STOP  = 3'd4,
    EV_CLEAR = 3'd5
  } ev_t;

  localparam int CNT_W_DEF = 24;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;
  localparam logic [CNT_W_DEF-1:0] CNT_MIN = '0;

  function automatic ev_t pick_event(
    input logic ev_clear,
    input logic ev_stop,
    input logic ev_start,
    input logic ev_dir,
    input logic ev_sel
  );
    if (ev_clear)      return EV_CLEAR;
    else if (ev_stop)  return EV_STOP;
    else if (ev_start) return EV_START;
    else if (ev_dir)   return EV_DIR;
    else if (ev_sel)   return EV_SEL;
    else               return EV_NONE;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - Two-flop synchronizer with rising-edge pulse for a raw pad input
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - Button-driven run/pause/limit sequencer for two up/down counters
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_dir,
  input  logic             btn_clear,
  input  logic             btn_sel,
  input  logic             sw_free,
  input  logic [CNT_W-1:0] count_in,
  output logic             enable1,
  output logic             enable2,
  output logic             up_down,
  output logic             free_run,
  output logic             clear,
  output logic             sel,
  output logic [1:0]       state,
  output logic             tick
);

  localparam int PW = $clog2(TICK_DIV);

  logic [4:0] btn_raw;
  logic [4:0] btn_rise;
  logic [4:0] btn_level_unused;
  logic       sw_free_rise_unused;

  assign btn_raw = {btn_clear, btn_stop, btn_start, btn_dir, btn_sel};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_edge u_btn (
      .clk   (clk),
      .reset (reset),
      .din   (btn_raw[i]),
      .level (btn_level_unused[i]),
      .rise  (btn_rise[i])
    );
  end

  btn_edge u_sw_free (
    .clk   (clk),
    .reset (reset),
    .din   (sw_free),
    .level (free_run),
    .rise  (sw_free_rise_unused)
  );

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          up_down_d, sel_d, tick_d, en1_d, en2_d, clear_d;
  logic          presc_last, at_limit;
  ev_t           ev;

  assign ev = pick_event(btn_rise[4], btn_rise[3], btn_rise[2], btn_rise[1], btn_rise[0]);

  assign presc_last = (presc_q == PW'(TICK_DIV - 1));

  // Limit uses the direction and count seen during the last prescaler cycle.
  assign at_limit = !free_run &&
                    (up_down ? (count_in == {CNT_W{CNT_MAX[0]}})
                             : (count_in == {CNT_W{CNT_MIN[0]}}));

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    up_down_d = up_down;
    sel_d     = sel;
    tick_d    = 1'b0;
    en1_d     = 1'b0;
    en2_d     = 1'b0;
    clear_d   = 1'b0;

    if (state_q == ST_RUN) begin
      presc_d = presc_last ? '0 : presc_q + PW'(1);
      if (presc_last) begin
        tick_d = 1'b1;
        if (at_limit) begin
          state_d = ST_LIMIT;
        end else begin
          en1_d = ~sel;
          en2_d = sel;
        end
      end
    end

    case (ev)
      EV_CLEAR: begin
        state_d = ST_IDLE;
        presc_d = '0;
        clear_d = 1'b1;
        tick_d  = 1'b0;
        en1_d   = 1'b0;
        en2_d   = 1'b0;
      end
      EV_STOP: begin
        if (state_q == ST_RUN) state_d = ST_PAUSE;
      end
      EV_START: begin
        if (state_q == ST_IDLE) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (state_q == ST_PAUSE) begin
          state_d = ST_RUN;
        end
      end
      EV_DIR: begin
        up_down_d = ~up_down;
        if (state_q == ST_LIMIT) state_d = ST_RUN;
      end
      EV_SEL: begin
        if (state_q == ST_IDLE || state_q == ST_PAUSE) sel_d = ~sel;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      up_down <= 1'b1;
      sel     <= 1'b0;
      tick    <= 1'b0;
      enable1 <= 1'b0;
      enable2 <= 1'b0;
      clear   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      up_down <= up_down_d;
      sel     <= sel_d;
      tick    <= tick_d;
      enable1 <= en1_d;
      enable2 <= en2_d;
      clear   <= clear_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - Directed self-checking bench for counter_sequencer
module tb_counter_sequencer;

  logic        clk;
  logic        reset;
  logic        btn_start, btn_stop, btn_dir, btn_clear, btn_sel, sw_free;
  logic [23:0] cnt;
  logic        enable1, enable2, up_down, free_run, clear, sel, tick;
  logic [1:0]  state;
  logic        load_req;
  logic [23:0] load_val;
  int          vecs;
  int          errs;

  counter_sequencer #(.TICK_DIV(4), .CNT_W(24)) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_start (btn_start),
    .btn_stop  (btn_stop),
    .btn_dir   (btn_dir),
    .btn_clear (btn_clear),
    .btn_sel   (btn_sel),
    .sw_free   (sw_free),
    .count_in  (cnt),
    .enable1   (enable1),
    .enable2   (enable2),
    .up_down   (up_down),
    .free_run  (free_run),
    .clear     (clear),
    .sel       (sel),
    .state     (state),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: counts on either strobe, or loads a forced value.
  always @(posedge clk) begin
    if (load_req)
      cnt <= load_val;
    else if (enable1 | enable2)
      cnt <= up_down ? cnt + 24'd1 : cnt - 24'd1;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic c, input logic sp, input logic st, input logic d, input logic s);
    btn_clear = c; btn_stop = sp; btn_start = st; btn_dir = d; btn_sel = s;
    step(1);
    btn_clear = 0; btn_stop = 0; btn_start = 0; btn_dir = 0; btn_sel = 0;
    step(2);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    vecs = 0; errs = 0;
    reset = 0;
    btn_start = 0; btn_stop = 0; btn_dir = 0; btn_clear = 0; btn_sel = 0;
    sw_free = 0;
    load_req = 1; load_val = 24'd100;
    step(3);
    check("rst_state",   32'(state),    32'd0);
    check("rst_up_down", 32'(up_down),  32'd1);
    check("rst_sel",     32'(sel),      32'd0);
    check("rst_en1",     32'(enable1),  32'd0);
    check("rst_en2",     32'(enable2),  32'd0);
    check("rst_clear",   32'(clear),    32'd0);
    check("rst_tick",    32'(tick),     32'd0);
    check("rst_free",    32'(free_run), 32'd0);
    reset = 1; load_req = 0;
    step(1);

    btn_start = 1; step(1); btn_start = 0;
    step(1);
    check("start_early", 32'(state), 32'd0);
    step(1);
    check("start_run", 32'(state), 32'd1);
    step(3);
    check("en1_before", 32'(enable1), 32'd0);
    step(1);
    check("en1_first",  32'(enable1), 32'd1);
    check("tick_first", 32'(tick),    32'd1);
    check("en2_quiet",  32'(enable2), 32'd0);
    step(1);
    check("en1_one_cycle", 32'(enable1), 32'd0);
    step(3);
    check("en1_second", 32'(enable1), 32'd1);

    press(0, 1, 0, 0, 0);
    check("stop_pause", 32'(state), 32'd2);
    check("pause_tick", 32'(tick),  32'd0);
    press(0, 0, 0, 0, 1);
    check("sel_in_pause", 32'(sel), 32'd1);
    step(4);
    press(0, 0, 1, 0, 0);
    check("resume_run",  32'(state), 32'd1);
    check("resume_tick0", 32'(tick), 32'd0);
    step(1);
    check("resume_tick", 32'(tick),    32'd1);
    check("resume_en2",  32'(enable2), 32'd1);
    check("resume_en1",  32'(enable1), 32'd0);
    press(0, 0, 0, 0, 1);
    check("sel_in_run", 32'(sel), 32'd1);
    step(1);
    check("en2_period", 32'(enable2), 32'd1);

    load_req = 1; load_val = 24'hFFFFFF;
    step(1);
    load_req = 0;
    step(3);
    check("limit_state", 32'(state),   32'd3);
    check("limit_tick",  32'(tick),    32'd1);
    check("limit_no_en", 32'(enable2), 32'd0);
    press(0, 0, 0, 1, 0);
    check("dir_updown", 32'(up_down), 32'd0);
    check("dir_run",    32'(state),   32'd1);
    step(3);
    check("dir_en_wait", 32'(enable2), 32'd0);
    step(1);
    check("dir_en2", 32'(enable2), 32'd1);

    press(1, 0, 1, 1, 0);
    check("clr_pulse",   32'(clear),   32'd1);
    check("clr_idle",    32'(state),   32'd0);
    check("clr_updown",  32'(up_down), 32'd0);
    check("clr_sel",     32'(sel),     32'd1);
    step(1);
    check("clr_one_cycle", 32'(clear), 32'd0);

    sw_free = 1; load_req = 1; load_val = 24'd0;
    btn_start = 1; step(1); btn_start = 0; load_req = 0;
    step(2);
    check("free_run_on", 32'(free_run), 32'd1);
    check("free_start",  32'(state),    32'd1);
    step(4);
    check("free_wrap_en2", 32'(enable2), 32'd1);
    #2 reset = 0;
    #1;
    check("arst_en1",    32'(enable1),  32'd0);
    check("arst_en2",    32'(enable2),  32'd0);
    check("arst_tick",   32'(tick),     32'd0);
    check("arst_state",  32'(state),    32'd0);
    check("arst_updown", 32'(up_down),  32'd1);
    check("arst_sel",    32'(sel),      32'd0);
    check("arst_free",   32'(free_run), 32'd0);
    check("arst_clear",  32'(clear),    32'd0);
    @(posedge clk);
    #1 reset = 1;
    step(2);
    check("post_rst_idle", 32'(state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Control block for the lab's two 24-bit up/down counter datapaths. Turns raw pushbutton and switch inputs into the per-counter enable strobes, direction, free-run and clear controls, paced by a programmable tick prescaler. Sits between the board I/O and the counter instances; the selected counter's current value is fed back so the sequencer can stop at the count limits.

## Interface
- `TICK_DIV`, 50_000_000: clk cycles per count tick. Must be ≥ 2; benches use 4.
- `CNT_W`, 24: counter width.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `btn_start` in 1: raw pushbutton; start or resume counting.
- `btn_stop` in 1: raw pushbutton; pause.
- `btn_dir` in 1: raw pushbutton; toggle direction.
- `btn_clear` in 1: raw pushbutton; clear and return to idle.
- `btn_sel` in 1: raw pushbutton; toggle the active counter.
- `sw_free` in 1: raw switch level; 1 = wrap at limits, 0 = saturate.
- `count_in` in CNT_W: current value of the selected counter.
- `enable1` out 1: one-cycle count strobe for counter 1.
- `enable2` out 1: one-cycle count strobe for counter 2.
- `up_down` out 1: 1 = up, 0 = down.
- `free_run` out 1: synchronized `sw_free`.
- `clear` out 1: one-cycle clear pulse to both counters.
- `sel` out 1: 0 = counter 1 active, 1 = counter 2 active.
- `state` out 2: current FSM state, for LEDs.
- `tick` out 1: one-cycle prescaler pulse.

## Operation
- Input conditioning:
  - Each `btn_*` input passes through a 2-FF synchronizer and a rising-edge detector, producing a one-cycle event.
  - `sw_free` passes through a 2-FF synchronizer only.
- Event priority, when several occur in the same cycle: clear > stop > start > dir > sel. Only the highest-priority event is acted on that cycle; the others are dropped.
- FSM states: IDLE = 00, RUN = 01, PAUSE = 10, LIMIT = 11.
  - clear, in any state: go to IDLE, pulse `clear`, zero the prescaler. `up_down` and `sel` are unchanged.
  - IDLE + start: go to RUN, zero the prescaler.
  - RUN + stop: go to PAUSE.
  - PAUSE + start: go to RUN. The prescaler holds its value through PAUSE and resumes from it.
  - RUN + tick, with `free_run`=0 and at the limit (`up_down`=1 and `count_in`=all-ones, or `up_down`=0 and `count_in`=0): go to LIMIT. No enable is issued on that tick.
  - LIMIT + dir: toggle `up_down`, go to RUN.
  - LIMIT + start: ignored.
  - dir in IDLE, RUN or PAUSE: toggle `up_down`; the state is unchanged.
  - sel in IDLE or PAUSE: toggle `sel`. sel in RUN or LIMIT: ignored.
- Prescaler:
  - Counts 0 .. TICK_DIV-1 only in RUN and wraps to 0.
  - `tick` is asserted on the cycle the prescaler equals TICK_DIV-1.
- Enable generation:
  - Condition: `tick` & state == RUN & no limit condition.
  - `enable1` is driven when `sel`=0; `enable2` when `sel`=1. Both are never high together.
- With `free_run`=1 no limit check is made; the datapath wraps on its own.

## Timing
- Reset values: `enable1`=0, `enable2`=0, `clear`=0, `tick`=0, `up_down`=1, `free_run`=0, `sel`=0, `state`=00, prescaler 0, all synchronizers 0.
- Reset is asynchronous on assertion. Deassertion is taken as synchronous to `clk` by the board-level reset logic.
- Reset mid-count drops any in-flight strobe immediately.
- All outputs are registered.
- Button latency: pad rises before clk edge k; the event is acted on at edge k+2; registered outputs and `state` change after edge k+2.
- A button held high produces exactly one event. A new event requires the button to go low for at least one synchronized sample.
- `tick` and its enable strobe are asserted in the same cycle, for exactly one cycle.
- With prescaler restart on IDLE→RUN, the first enable comes TICK_DIV cycles after `state` becomes RUN.
- `count_in` is sampled in the tick cycle. The datapath updates one cycle after the strobe, so consecutive strobes at least 2 cycles apart always see the updated value; this is why `TICK_DIV` must be ≥ 2.
- Limit check uses the `up_down` value in effect during the tick cycle.

## Structure
- Package `counter_seq_pkg` holds:
  - state encodings (IDLE, RUN, PAUSE, LIMIT as 2-bit constants);
  - `CNT_MAX` = all-ones and `CNT_MIN` = 0 at CNT_W;
  - the priority order, as documented constants.
- Sub-module `btn_edge` (2-FF sync + rising-edge pulse, asynchronous active-low reset) is instantiated five times. `sw_free` uses the same sync stage with edge output unused.
- Top level holds the FSM, prescaler, enable steering and direction/select registers.

## Test plan
- Reset, then start with `TICK_DIV`=4, `sel`=0, `count_in` advancing → `state`=01 three cycles after pad edge; `enable1` pulses every 4 cycles; `enable2` stays 0.
- `sw_free`=0, up, `count_in`=24'hFFFFFF at tick → `state`=11, no enable. Then dir → `up_down`=0, `state`=01, next tick pulses enable.
- stop mid-prescale (prescaler=2), start 10 cycles later → first tick arrives 1 cycle after `state` returns to RUN (prescaler held).
- clear, start and dir pressed in the same cycle while in RUN → `clear` one-cycle pulse, `state`=00, `up_down` unchanged.
- sel pressed in RUN → `sel` unchanged. sel pressed in PAUSE → `sel`=1; after resume, only `enable2` pulses.
- `reset` asserted in the cycle `tick` is high → `enable1`/`enable2` immediately 0; all outputs at reset values; `up_down`=1.
